core_pipe_dispatch: RTL and testbench

Decode-to-execute pipeline boundary. Sits between the decode stage (s1) and `core_pipe_exec` (s2), and holds the decoded instruction bundle in a registered output stage backed by a one-entry skid buffer. It patches register-sourced operands with same-cycle execute writeback data so that no read-after-write hazard is lost across the boundary. It also discards all held instructions when execute commits a control-flow change.

---
 rtl/core_pipe_dispatch_pkg.sv | 55 +++++
 rtl/core_pipe_dispatch_byp.sv | 27 ++
 rtl/core_pipe_dispatch.sv | 163 ++++++++++++++++
 tb/tb_core_pipe_dispatch.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pipe_dispatch_pkg.sv
// Shared core constants and decode/dispatch bundle types.
// Op-field widths are range indices (field width = *_R + 1).
package core_pipe_dispatch_pkg;

  localparam int CORE_XLEN  = 64;
  localparam int ALU_OP_R   = 5;
  localparam int LSU_OP_R   = 3;
  localparam int MDU_OP_R   = 2;
  localparam int CSR_OP_R   = 2;
  localparam int CFU_OP_R   = 2;
  localparam int REG_ADDR_R = 4;

  localparam logic [ALU_OP_R:0] ALU_OP_NOP = '0;
  localparam logic [CFU_OP_R:0] CFU_OP_NOP = '0;

  typedef enum logic [1:0] {
    DSP_EMPTY = 2'd0,
    DSP_ONE   = 2'd1,
    DSP_FULL  = 2'd2
  } dispatch_state_t;

  typedef struct packed {
    logic [CORE_XLEN-1:0]  pc;
    logic [CORE_XLEN-1:0]  opr_a;
    logic [CORE_XLEN-1:0]  opr_b;
    logic [CORE_XLEN-1:0]  opr_c;
    logic [REG_ADDR_R:0]   rd;
    logic [ALU_OP_R:0]     alu_op;
    logic [LSU_OP_R:0]     lsu_op;
    logic [MDU_OP_R:0]     mdu_op;
    logic [CSR_OP_R:0]     csr_op;
    logic [CFU_OP_R:0]     cfu_op;
    logic                  op_w;
    logic [31:0]           instr;
  } dispatch_bundle_t;

  // Skid entry keeps source tags so it can still be patched while waiting.
  typedef struct packed {
    dispatch_bundle_t      b;
    logic [REG_ADDR_R:0]   rs1;
    logic [REG_ADDR_R:0]   rs2;
    logic                  a_rs1;
    logic                  b_rs2;
    logic                  c_rs2;
  } dispatch_skid_t;

  function automatic dispatch_bundle_t bundle_reset();
    dispatch_bundle_t r;
    r        = '0;
    r.alu_op = ALU_OP_NOP;
    r.cfu_op = CFU_OP_NOP;
    return r;
  endfunction

endpackage

// File: rtl/core_pipe_dispatch_byp.sv
// Combinational operand patcher: replaces register-sourced operands
// with the execute writeback value when the source register matches.
module core_pipe_dispatch_byp
  import core_pipe_dispatch_pkg::*;
(
  input  logic                 wen,
  input  logic [REG_ADDR_R:0]  waddr,
  input  logic [CORE_XLEN-1:0] wdata,
  input  dispatch_skid_t       src,
  output dispatch_skid_t       dst
);

  logic hit_rs1;
  logic hit_rs2;

  // x0 writes are architecturally discarded, so never forward them.
  assign hit_rs1 = wen && (waddr == src.rs1) && (waddr != '0);
  assign hit_rs2 = wen && (waddr == src.rs2) && (waddr != '0);

  always_comb begin
    dst = src;
    if (hit_rs1 && src.a_rs1) dst.b.opr_a = wdata;
    if (hit_rs2 && src.b_rs2) dst.b.opr_b = wdata;
    if (hit_rs2 && src.c_rs2) dst.b.opr_c = wdata;
  end

endmodule

// File: rtl/core_pipe_dispatch.sv
// Decode-to-execute boundary: registered output stage plus one-entry skid,
// with writeback forwarding at capture and while parked in the skid.
//   state     | meaning
//   DSP_EMPTY | out register invalid
//   DSP_ONE   | out register valid, skid empty
//   DSP_FULL  | out register and skid both valid
module core_pipe_dispatch
  import core_pipe_dispatch_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                s1_valid,
  output logic                s1_ready,
  input  logic [XLEN-1:0]     s1_pc,
  input  logic [XLEN-1:0]     s1_opr_a,
  input  logic [XLEN-1:0]     s1_opr_b,
  input  logic [XLEN-1:0]     s1_opr_c,
  input  logic [REG_ADDR_R:0] s1_rd,
  input  logic [REG_ADDR_R:0] s1_rs1,
  input  logic [REG_ADDR_R:0] s1_rs2,
  input  logic                s1_a_rs1,
  input  logic                s1_b_rs2,
  input  logic                s1_c_rs2,
  input  logic [ALU_OP_R:0]   s1_alu_op,
  input  logic [LSU_OP_R:0]   s1_lsu_op,
  input  logic [MDU_OP_R:0]   s1_mdu_op,
  input  logic [CSR_OP_R:0]   s1_csr_op,
  input  logic [CFU_OP_R:0]   s1_cfu_op,
  input  logic                s1_op_w,
  input  logic [31:0]         s1_instr,
  output logic                s2_valid,
  input  logic                s2_ready,
  output logic [XLEN-1:0]     s2_pc,
  output logic [XLEN-1:0]     s2_opr_a,
  output logic [XLEN-1:0]     s2_opr_b,
  output logic [XLEN-1:0]     s2_opr_c,
  output logic [REG_ADDR_R:0] s2_rd,
  output logic [ALU_OP_R:0]   s2_alu_op,
  output logic [LSU_OP_R:0]   s2_lsu_op,
  output logic [MDU_OP_R:0]   s2_mdu_op,
  output logic [CSR_OP_R:0]   s2_csr_op,
  output logic [CFU_OP_R:0]   s2_cfu_op,
  output logic                s2_op_w,
  output logic [31:0]         s2_instr,
  input  logic                s2_rd_wen,
  input  logic [REG_ADDR_R:0] s2_rd_addr,
  input  logic [XLEN-1:0]     s2_rd_wdata,
  input  logic                cf_flush
);

  dispatch_state_t  state_q, state_d;
  logic             ready_q;
  dispatch_bundle_t out_q;
  dispatch_skid_t   skid_q, skid_byp;
  dispatch_skid_t   cap_raw, cap_byp;
  logic             accept, drain;
  logic             load_out, load_skid, move_skid;

  always_comb begin
    cap_raw          = '0;
    cap_raw.b.pc     = s1_pc;
    cap_raw.b.opr_a  = s1_opr_a;
    cap_raw.b.opr_b  = s1_opr_b;
    cap_raw.b.opr_c  = s1_opr_c;
    cap_raw.b.rd     = s1_rd;
    cap_raw.b.alu_op = s1_alu_op;
    cap_raw.b.lsu_op = s1_lsu_op;
    cap_raw.b.mdu_op = s1_mdu_op;
    cap_raw.b.csr_op = s1_csr_op;
    cap_raw.b.cfu_op = s1_cfu_op;
    cap_raw.b.op_w   = s1_op_w;
    cap_raw.b.instr  = s1_instr;
    cap_raw.rs1      = s1_rs1;
    cap_raw.rs2      = s1_rs2;
    cap_raw.a_rs1    = s1_a_rs1;
    cap_raw.b_rs2    = s1_b_rs2;
    cap_raw.c_rs2    = s1_c_rs2;
  end

  core_pipe_dispatch_byp u_byp_cap (
    .wen   (s2_rd_wen),
    .waddr (s2_rd_addr),
    .wdata (s2_rd_wdata),
    .src   (cap_raw),
    .dst   (cap_byp)
  );

  core_pipe_dispatch_byp u_byp_skid (
    .wen   (s2_rd_wen),
    .waddr (s2_rd_addr),
    .wdata (s2_rd_wdata),
    .src   (skid_q),
    .dst   (skid_byp)
  );

  assign s1_ready = ready_q;
  assign s2_valid = (state_q != DSP_EMPTY);
  assign accept   = s1_valid && ready_q;
  assign drain    = s2_valid && s2_ready;

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (cf_flush) begin
      state_d = DSP_EMPTY;
    end else begin
      case (state_q)
        DSP_EMPTY: if (accept) begin
          state_d  = DSP_ONE;
          load_out = 1'b1;
        end
        DSP_ONE: if (accept && drain) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_d   = DSP_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = DSP_EMPTY;
        end
        DSP_FULL: if (drain) begin
          state_d   = DSP_ONE;
          move_skid = 1'b1;
        end
        default: state_d = DSP_EMPTY;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= DSP_EMPTY;
      ready_q <= 1'b1;
      out_q   <= bundle_reset();
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != DSP_FULL);
      if (load_out)       out_q <= cap_byp.b;
      else if (move_skid) out_q <= skid_byp.b;
      // The parked entry keeps absorbing writebacks until it moves out.
      if (load_skid)                 skid_q <= cap_byp;
      else if (state_q == DSP_FULL)  skid_q <= skid_byp;
    end
  end

  assign s2_pc     = out_q.pc;
  assign s2_opr_a  = out_q.opr_a;
  assign s2_opr_b  = out_q.opr_b;
  assign s2_opr_c  = out_q.opr_c;
  assign s2_rd     = out_q.rd;
  assign s2_alu_op = out_q.alu_op;
  assign s2_lsu_op = out_q.lsu_op;
  assign s2_mdu_op = out_q.mdu_op;
  assign s2_csr_op = out_q.csr_op;
  assign s2_cfu_op = out_q.cfu_op;
  assign s2_op_w   = out_q.op_w;
  assign s2_instr  = out_q.instr;

endmodule

// File: tb/tb_core_pipe_dispatch.sv
// Self-checking bench for core_pipe_dispatch: directed vector table, corner
// sequences, then random traffic against a two-entry queue reference model.
module tb_core_pipe_dispatch;
  import core_pipe_dispatch_pkg::*;

  logic                g_clk;
  logic                g_resetn;
  logic                s1_valid, s1_ready;
  logic [63:0]         s1_pc, s1_opr_a, s1_opr_b, s1_opr_c;
  logic [REG_ADDR_R:0] s1_rd, s1_rs1, s1_rs2;
  logic                s1_a_rs1, s1_b_rs2, s1_c_rs2;
  logic [ALU_OP_R:0]   s1_alu_op;
  logic [LSU_OP_R:0]   s1_lsu_op;
  logic [MDU_OP_R:0]   s1_mdu_op;
  logic [CSR_OP_R:0]   s1_csr_op;
  logic [CFU_OP_R:0]   s1_cfu_op;
  logic                s1_op_w;
  logic [31:0]         s1_instr;
  logic                s2_valid, s2_ready;
  logic [63:0]         s2_pc, s2_opr_a, s2_opr_b, s2_opr_c;
  logic [REG_ADDR_R:0] s2_rd;
  logic [ALU_OP_R:0]   s2_alu_op;
  logic [LSU_OP_R:0]   s2_lsu_op;
  logic [MDU_OP_R:0]   s2_mdu_op;
  logic [CSR_OP_R:0]   s2_csr_op;
  logic [CFU_OP_R:0]   s2_cfu_op;
  logic                s2_op_w;
  logic [31:0]         s2_instr;
  logic                s2_rd_wen;
  logic [REG_ADDR_R:0] s2_rd_addr;
  logic [63:0]         s2_rd_wdata;
  logic                cf_flush;

  int n_chk = 0;
  int n_err = 0;

  core_pipe_dispatch #(.XLEN(64)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .s1_valid(s1_valid), .s1_ready(s1_ready),
    .s1_pc(s1_pc), .s1_opr_a(s1_opr_a), .s1_opr_b(s1_opr_b), .s1_opr_c(s1_opr_c),
    .s1_rd(s1_rd), .s1_rs1(s1_rs1), .s1_rs2(s1_rs2),
    .s1_a_rs1(s1_a_rs1), .s1_b_rs2(s1_b_rs2), .s1_c_rs2(s1_c_rs2),
    .s1_alu_op(s1_alu_op), .s1_lsu_op(s1_lsu_op), .s1_mdu_op(s1_mdu_op),
    .s1_csr_op(s1_csr_op), .s1_cfu_op(s1_cfu_op), .s1_op_w(s1_op_w), .s1_instr(s1_instr),
    .s2_valid(s2_valid), .s2_ready(s2_ready),
    .s2_pc(s2_pc), .s2_opr_a(s2_opr_a), .s2_opr_b(s2_opr_b), .s2_opr_c(s2_opr_c),
    .s2_rd(s2_rd), .s2_alu_op(s2_alu_op), .s2_lsu_op(s2_lsu_op), .s2_mdu_op(s2_mdu_op),
    .s2_csr_op(s2_csr_op), .s2_cfu_op(s2_cfu_op), .s2_op_w(s2_op_w), .s2_instr(s2_instr),
    .s2_rd_wen(s2_rd_wen), .s2_rd_addr(s2_rd_addr), .s2_rd_wdata(s2_rd_wdata),
    .cf_flush(cf_flush)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  logic [63:0] s2_misc;
  assign s2_misc = {7'd0, s2_rd, s2_alu_op, s2_lsu_op, s2_mdu_op, s2_csr_op,
                    s2_cfu_op, s2_op_w, s2_instr};

  typedef struct {
    logic [63:0] pc, a, b, c, misc;
    logic [4:0]  rs1, rs2;
    logic        fa, fb, fc;
  } ent_t;

  ent_t mq[$];
  logic m_ready;

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic        rdy;
    logic        fl;
    logic        ev;
    logic        er;
    logic [63:0] epc;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic clr_in();
    s1_valid = 0; s1_pc = '0; s1_opr_a = '0; s1_opr_b = '0; s1_opr_c = '0;
    s1_rd = '0; s1_rs1 = '0; s1_rs2 = '0; s1_a_rs1 = 0; s1_b_rs2 = 0; s1_c_rs2 = 0;
    s1_alu_op = '0; s1_lsu_op = '0; s1_mdu_op = '0; s1_csr_op = '0; s1_cfu_op = '0;
    s1_op_w = 0; s1_instr = '0; s2_ready = 1; s2_rd_wen = 0; s2_rd_addr = '0;
    s2_rd_wdata = '0; cf_flush = 0;
  endtask

  task automatic do_reset();
    g_resetn = 0;
    step();
    g_resetn = 1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_s2_valid"}, {63'd0, s2_valid}, 64'd0);
    chk({tag, "_s1_ready"}, {63'd0, s1_ready}, 64'd1);
    chk({tag, "_pc"}, s2_pc, 64'd0);
    chk({tag, "_opr_a"}, s2_opr_a, 64'd0);
    chk({tag, "_opr_b"}, s2_opr_b, 64'd0);
    chk({tag, "_opr_c"}, s2_opr_c, 64'd0);
    chk({tag, "_misc"}, s2_misc, 64'd0);
  endtask

  function automatic logic hit(input logic [4:0] src);
    return s2_rd_wen && (s2_rd_addr == src) && (s2_rd_addr != 5'd0);
  endfunction

  function automatic ent_t patch(input ent_t e);
    ent_t r = e;
    if (hit(e.rs1) && e.fa) r.a = s2_rd_wdata;
    if (hit(e.rs2) && e.fb) r.b = s2_rd_wdata;
    if (hit(e.rs2) && e.fc) r.c = s2_rd_wdata;
    return r;
  endfunction

  // Occupancy as a queue: front is what execute sees, second is waiting.
  task automatic model_step();
    ent_t e;
    logic acc, drn;
    acc = s1_valid && m_ready;
    drn = (mq.size() > 0) && s2_ready;
    if (cf_flush) begin
      mq.delete();
    end else begin
      if (mq.size() == 2) mq[1] = patch(mq[1]);
      if (drn) void'(mq.pop_front());
      if (acc) begin
        e.pc = s1_pc; e.a = s1_opr_a; e.b = s1_opr_b; e.c = s1_opr_c;
        e.misc = {7'd0, s1_rd, s1_alu_op, s1_lsu_op, s1_mdu_op, s1_csr_op,
                  s1_cfu_op, s1_op_w, s1_instr};
        e.rs1 = s1_rs1; e.rs2 = s1_rs2;
        e.fa = s1_a_rs1; e.fb = s1_b_rs2; e.fc = s1_c_rs2;
        mq.push_back(patch(e));
      end
    end
    m_ready = (mq.size() < 2);
  endtask

  task automatic rand_in();
    logic [31:0] r;
    r = $urandom();
    s1_valid  = (r[1:0] != 2'd0);
    s2_ready  = (r[3:2] != 2'd0);
    cf_flush  = (r[7:4] == 4'd0);
    s2_rd_wen = r[8];
    s1_a_rs1  = r[9]; s1_b_rs2 = r[10]; s1_c_rs2 = r[11];
    s1_op_w   = r[12];
    s2_rd_addr = {2'b00, r[15:13]};
    s1_rs1     = {2'b00, r[18:16]};
    s1_rs2     = {2'b00, r[21:19]};
    s1_rd      = r[26:22];
    r = $urandom();
    s1_alu_op = r[ALU_OP_R:0];
    s1_lsu_op = r[10:10-LSU_OP_R];
    s1_mdu_op = r[14:14-MDU_OP_R];
    s1_csr_op = r[18:18-CSR_OP_R];
    s1_cfu_op = r[22:22-CFU_OP_R];
    s1_pc       = {$urandom(), $urandom()};
    s1_opr_a    = {$urandom(), $urandom()};
    s1_opr_b    = {$urandom(), $urandom()};
    s1_opr_c    = {$urandom(), $urandom()};
    s1_instr    = $urandom();
    s2_rd_wdata = {$urandom(), $urandom()};
  endtask

  initial begin
    // v, pc, s2_ready, flush | exp s2_valid, exp s1_ready, exp s2_pc
    tbl[0]  = '{1'b1, 64'h100, 1'b0, 1'b0, 1'b1, 1'b1, 64'h100};
    tbl[1]  = '{1'b1, 64'h104, 1'b0, 1'b0, 1'b1, 1'b0, 64'h100};
    tbl[2]  = '{1'b1, 64'h108, 1'b0, 1'b0, 1'b1, 1'b0, 64'h100};
    tbl[3]  = '{1'b1, 64'h108, 1'b1, 1'b0, 1'b1, 1'b1, 64'h104};
    tbl[4]  = '{1'b1, 64'h108, 1'b1, 1'b0, 1'b1, 1'b1, 64'h108};
    tbl[5]  = '{1'b0, 64'h0,   1'b1, 1'b0, 1'b0, 1'b1, 64'h0};
    tbl[6]  = '{1'b1, 64'h200, 1'b0, 1'b0, 1'b1, 1'b1, 64'h200};
    tbl[7]  = '{1'b1, 64'h204, 1'b0, 1'b0, 1'b1, 1'b0, 64'h200};
    tbl[8]  = '{1'b1, 64'h208, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0};
    tbl[9]  = '{1'b1, 64'h20C, 1'b0, 1'b0, 1'b1, 1'b1, 64'h20C};
    tbl[10] = '{1'b0, 64'h0,   1'b1, 1'b0, 1'b0, 1'b1, 64'h0};

    clr_in();
    g_resetn = 0;
    step();
    chk_reset_state("reset");
    g_resetn = 1;

    // Streaming with execute always ready.
    for (int i = 0; i < 8; i++) begin
      s1_valid = 1; s1_pc = 64'(4 * i);
      step();
      chk("stream_valid", {63'd0, s2_valid}, 64'd1);
      chk("stream_ready", {63'd0, s1_ready}, 64'd1);
      chk("stream_pc", s2_pc, 64'(4 * i));
    end
    clr_in();
    step();
    chk("stream_idle", {63'd0, s2_valid}, 64'd0);

    // Backpressure and flush vector table.
    for (int i = 0; i < 11; i++) begin
      s1_valid = tbl[i].v; s1_pc = tbl[i].pc; s2_ready = tbl[i].rdy; cf_flush = tbl[i].fl;
      step();
      chk($sformatf("tbl%0d_valid", i), {63'd0, s2_valid}, {63'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_ready", i), {63'd0, s1_ready}, {63'd0, tbl[i].er});
      if (tbl[i].ev) chk($sformatf("tbl%0d_pc", i), s2_pc, tbl[i].epc);
    end
    clr_in();

    // Capture bypass: hit on rs1, then same with x0, then rs2 onto b only.
    s1_valid = 1; s1_rs1 = 5'd5; s1_a_rs1 = 1; s1_opr_a = 64'h11;
    s2_rd_wen = 1; s2_rd_addr = 5'd5; s2_rd_wdata = 64'hDEAD;
    step();
    chk("cap_byp_a", s2_opr_a, 64'hDEAD);
    s2_rd_addr = 5'd0;
    step();
    chk("cap_byp_x0", s2_opr_a, 64'h11);
    s1_a_rs1 = 0; s1_rs2 = 5'd3; s1_b_rs2 = 1; s1_opr_b = 64'h22; s1_opr_c = 64'h33;
    s2_rd_addr = 5'd3;
    step();
    chk("cap_byp_b", s2_opr_b, 64'hDEAD);
    chk("cap_byp_c_nohit", s2_opr_c, 64'h33);
    clr_in();
    step();

    // Skid bypass: writeback arrives while parked.
    s2_ready = 0; s1_valid = 1; s1_pc = 64'h300;
    step();
    s1_pc = 64'h304; s1_rs2 = 5'd7; s1_c_rs2 = 1; s1_opr_c = 64'h55;
    step();
    chk("skid_full", {63'd0, s1_ready}, 64'd0);
    clr_in(); s2_ready = 0;
    s2_rd_wen = 1; s2_rd_addr = 5'd7; s2_rd_wdata = 64'h1234;
    step();
    s2_rd_wen = 0; s2_ready = 1;
    step();
    chk("skid_pc", s2_pc, 64'h304);
    chk("skid_byp_c", s2_opr_c, 64'h1234);
    step();

    // Skid bypass in the same cycle as the drain.
    s2_ready = 0; s1_valid = 1; s1_pc = 64'h400;
    step();
    s1_pc = 64'h404; s1_rs2 = 5'd7; s1_c_rs2 = 1; s1_opr_c = 64'h55;
    step();
    clr_in();
    s2_rd_wen = 1; s2_rd_addr = 5'd7; s2_rd_wdata = 64'h9999;
    step();
    chk("skid_drain_pc", s2_pc, 64'h404);
    chk("skid_drain_c", s2_opr_c, 64'h9999);
    clr_in();
    step();

    // Reset mid-stream while FULL.
    s2_ready = 0; s1_valid = 1; s1_pc = 64'h500; s1_opr_a = 64'hA5; s1_instr = 32'hFFFF;
    s1_alu_op = '1; s1_cfu_op = '1; s1_rd = 5'd9;
    step();
    s1_pc = 64'h504;
    step();
    chk("rstmid_full", {63'd0, s1_ready}, 64'd0);
    g_resetn = 0;
    step();
    chk_reset_state("rstmid");
    g_resetn = 1;
    clr_in();

    // Random traffic against the queue model.
    do_reset();
    mq.delete();
    m_ready = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rand_in();
      model_step();
      step();
      chk("rnd_valid", {63'd0, s2_valid}, {63'd0, (mq.size() > 0)});
      chk("rnd_ready", {63'd0, s1_ready}, {63'd0, m_ready});
      if (mq.size() > 0) begin
        chk("rnd_pc", s2_pc, mq[0].pc);
        chk("rnd_a", s2_opr_a, mq[0].a);
        chk("rnd_b", s2_opr_b, mq[0].b);
        chk("rnd_c", s2_opr_c, mq[0].c);
        chk("rnd_misc", s2_misc, mq[0].misc);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
